// File: rtl/sls_sequencer.sv
// Multi-cycle load/store sequencer for addressing-mode-2/3 transfers (byte, half, word, doubleword).
// Define SLS_ALIGN_CHECK_EN to add alignment-fault detection and the abort output.
module sls_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int DW_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       ir,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    input  logic [31:0]       st_data_hi,
    output logic              busy,
    output logic              done,
    output logic [31:0]       ld_data,
    output logic [31:0]       ld_data_hi,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
`ifdef SLS_ALIGN_CHECK_EN
    output logic              abort,
`endif
    input  logic [31:0]       mem_rdata,
    input  logic              mem_moc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [1:0] K_BYTE  = 2'd0;
    localparam logic [1:0] K_HALF  = 2'd1;
    localparam logic [1:0] K_WORD  = 2'd2;
    localparam logic [1:0] K_DWORD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        kind_q, kind_d;
    logic              sgn_q, sgn_d;
    logic [31:0]       hi_q, hi_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       ld_q, ld_d;
    logic [31:0]       ld_hi_q, ld_hi_d;
`ifdef SLS_ALIGN_CHECK_EN
    logic              abort_q, abort_d;
`endif

    logic        dec_valid;
    logic [1:0]  dec_kind;
    logic        dec_sgn;
    logic        dec_read;
    logic        fault;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;
    logic        unused_ir;

    assign unused_ir = ^{ir[31:28], ir[24:23], ir[21], ir[19:8], ir[3:0]};

    always_comb begin
        dec_valid = 1'b0;
        dec_kind  = K_WORD;
        dec_sgn   = 1'b0;
        dec_read  = ir[20];
        if (ir[27:26] == 2'b01) begin
            dec_valid = 1'b1;
            dec_kind  = ir[22] ? K_BYTE : K_WORD;
        end else if (ir[27:25] == 3'b000 && ir[7] && ir[4]) begin
            // With L=0, SH=10/11 are the doubleword load/store rather than signed loads
            case (ir[6:5])
                2'b01: begin
                    dec_valid = 1'b1;
                    dec_kind  = K_HALF;
                end
                2'b10: begin
                    dec_valid = 1'b1;
                    dec_kind  = ir[20] ? K_BYTE : K_DWORD;
                    dec_sgn   = ir[20];
                    dec_read  = 1'b1;
                end
                2'b11: begin
                    dec_valid = 1'b1;
                    dec_kind  = ir[20] ? K_HALF : K_DWORD;
                    dec_sgn   = ir[20];
                end
                default: dec_valid = 1'b0;
            endcase
        end
    end

`ifdef SLS_ALIGN_CHECK_EN
    always_comb begin
        case (dec_kind)
            K_HALF:  fault = addr[0];
            K_WORD:  fault = (addr[1:0] != 2'b00);
            K_DWORD: fault = (addr[2:0] != 3'b000);
            default: fault = 1'b0;
        endcase
    end
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        case (dec_kind)
            K_BYTE: begin
                lane_be    = 4'b0001 << addr[1:0];
                lane_wdata = {4{st_data[7:0]}};
            end
            K_HALF: begin
                lane_be    = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{st_data[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = st_data;
            end
        endcase
    end

    // Lane extraction uses the latched address, which is unchanged during the first beat
    always_comb begin
        rd_byte = mem_rdata[{mem_addr_q[1:0], 3'b000} +: 8];
        rd_half = mem_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (kind_q)
            K_BYTE:  rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            K_HALF:  rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        sgn_d       = sgn_q;
        hi_d        = hi_q;
        mem_req_d   = mem_req_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        ld_d        = ld_q;
        ld_hi_d     = ld_hi_q;
`ifdef SLS_ALIGN_CHECK_EN
        abort_d     = abort_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dec_valid && !fault) begin
                        state_d     = S_ACC0;
                        kind_d      = dec_kind;
                        sgn_d       = dec_sgn;
                        hi_d        = st_data_hi;
                        mem_req_d   = 1'b1;
                        mem_rw_d    = dec_read;
                        mem_addr_d  = addr;
                        mem_be_d    = lane_be;
                        mem_wdata_d = lane_wdata;
                    end else begin
                        state_d = S_FIN;
`ifdef SLS_ALIGN_CHECK_EN
                        abort_d = dec_valid;
`endif
                    end
                end
            end
            S_ACC0: begin
                if (mem_moc) begin
                    if (mem_rw_q) begin
                        ld_d = rd_ext;
                    end
                    if (kind_q == K_DWORD) begin
                        state_d     = S_ACC1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(DW_STRIDE);
                        mem_wdata_d = hi_q;
                    end else begin
                        state_d   = S_FIN;
                        mem_req_d = 1'b0;
                    end
                end
            end
            S_ACC1: begin
                if (mem_moc) begin
                    if (mem_rw_q) begin
                        ld_hi_d = mem_rdata;
                    end
                    state_d   = S_FIN;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
`ifdef SLS_ALIGN_CHECK_EN
                abort_d = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kind_q      <= K_WORD;
            sgn_q       <= 1'b0;
            hi_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            ld_q        <= '0;
            ld_hi_q     <= '0;
`ifdef SLS_ALIGN_CHECK_EN
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            sgn_q       <= sgn_d;
            hi_q        <= hi_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            ld_q        <= ld_d;
            ld_hi_q     <= ld_hi_d;
`ifdef SLS_ALIGN_CHECK_EN
            abort_q     <= abort_d;
`endif
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign mem_req    = mem_req_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign ld_data    = ld_q;
    assign ld_data_hi = ld_hi_q;
`ifdef SLS_ALIGN_CHECK_EN
    assign abort      = abort_q;
`endif

endmodule

// File: tb/tb_sls_sequencer.sv
// Scoreboard bench for sls_sequencer: a reference model queues expected beats and completions,
// independent monitors compare them against the memory-side handshake and the done pulse.
module tb_sls_sequencer;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   ir;
    logic [AW-1:0] addr;
    logic [31:0]   st_data, st_data_hi;
    logic          busy, done;
    logic [31:0]   ld_data, ld_data_hi;
    logic          mem_req, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_moc;
`ifdef SLS_ALIGN_CHECK_EN
    logic          abort;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          last;
    } beat_t;

    typedef struct {
        logic [31:0] ld;
        logic [31:0] ld_hi;
        bit          abrt;
        bit          access;
        int          start_cyc;
    } res_t;

    beat_t       beat_q[$];
    res_t        res_q[$];
    logic [31:0] pre_mem[logic [31:0]];
    logic [31:0] exp_ld = '0;
    logic [31:0] exp_ld_hi = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fixed_delay = -1;
    int          last_beat_cyc = 0;

    sls_sequencer #(.ADDR_W(AW), .DW_STRIDE(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .addr(addr),
        .st_data(st_data), .st_data_hi(st_data_hi), .busy(busy), .done(done),
        .ld_data(ld_data), .ld_data_hi(ld_data_hi), .mem_req(mem_req), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
`ifdef SLS_ALIGN_CHECK_EN
        .abort(abort),
`endif
        .mem_rdata(mem_rdata), .mem_moc(mem_moc)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] val);
        checks++;
        errors++;
        $display("FAIL %s value %h (cycle %0d)", name, val, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (pre_mem.exists(wa)) return pre_mem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // Reference model: classify the transfer by size/sign/direction, then list its beats and result
    task automatic model_push(input logic [31:0] ir_v, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] dh, input int c0);
        int          size, off, nb;
        bit          sgn, is_ld, valid, flt;
        beat_t       b;
        res_t        r;
        logic [31:0] w;
        logic [7:0]  bt;
        logic [15:0] hw;
        valid = 0; size = 4; sgn = 0; is_ld = ir_v[20];
        if (ir_v[27:26] == 2'b01) begin
            valid = 1;
            size  = ir_v[22] ? 1 : 4;
        end else if (ir_v[27:25] == 3'b000 && ir_v[7] && ir_v[4] && ir_v[6:5] != 2'b00) begin
            valid = 1;
            case ({ir_v[20], ir_v[6:5]})
                3'b101:  size = 2;
                3'b110:  begin size = 1; sgn = 1; end
                3'b111:  begin size = 2; sgn = 1; end
                3'b001:  size = 2;
                3'b010:  begin size = 8; is_ld = 1; end
                default: begin size = 8; is_ld = 0; end
            endcase
        end
        flt = 0;
`ifdef SLS_ALIGN_CHECK_EN
        if (valid && size > 1 && (int'(a[2:0]) % size) != 0) flt = 1;
`endif
        r.access    = valid && !flt;
        r.abrt      = flt;
        r.start_cyc = c0;
        if (r.access) begin
            off = int'(a[1:0]);
            nb  = (size == 8) ? 2 : 1;
            for (int k = 0; k < nb; k++) begin
                b.addr = a + 32'(4 * k);
                b.rw   = is_ld;
                b.last = (k == nb - 1);
                if (size == 1) begin
                    b.be    = 4'b0001 << off;
                    b.wdata = {4{d[7:0]}};
                end else if (size == 2) begin
                    b.be    = (off >= 2) ? 4'b1100 : 4'b0011;
                    b.wdata = {2{d[15:0]}};
                end else begin
                    b.be    = 4'b1111;
                    b.wdata = (k == 1) ? dh : d;
                end
                beat_q.push_back(b);
            end
            if (is_ld) begin
                w = mem_word(a);
                if (size == 1) begin
                    bt     = 8'(w >> (8 * off));
                    exp_ld = sgn ? 32'($signed(bt)) : {24'h0, bt};
                end else if (size == 2) begin
                    hw     = (off >= 2) ? w[31:16] : w[15:0];
                    exp_ld = sgn ? 32'($signed(hw)) : {16'h0, hw};
                end else begin
                    exp_ld = w;
                end
                if (size == 8) exp_ld_hi = mem_word(a + 32'd4);
            end
        end
        r.ld    = exp_ld;
        r.ld_hi = exp_ld_hi;
        res_q.push_back(r);
    endtask

    // Memory responder: per-beat latency, random junk rdata and stray moc while idle
    initial begin
        int cnt;
        cnt = -1;
        mem_moc   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata = $urandom;
            if (!rst_n || !mem_req) begin
                mem_moc = ($urandom_range(0, 7) == 0);
                cnt     = -1;
            end else begin
                if (cnt < 0) cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    mem_moc   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    cnt       = -1;
                end else begin
                    mem_moc = 1'b0;
                    cnt--;
                end
            end
        end
    end

    // Beat monitor
    initial forever begin
        beat_t b;
        @(negedge clk);
        if (rst_n && mem_req && mem_moc) begin
            if (beat_q.size() == 0) begin
                note_fail("beat_unexpected", mem_addr);
            end else begin
                b = beat_q.pop_front();
                chk("beat_addr", mem_addr, b.addr);
                chk("beat_rw", 32'(mem_rw), 32'(b.rw));
                chk("beat_be", 32'(mem_be), 32'(b.be));
                if (!b.rw) chk("beat_wdata", mem_wdata, b.wdata);
                if (b.last) last_beat_cyc = cyc;
                $display("beat addr=%h rw=%0d be=%b wdata=%h", mem_addr, mem_rw, mem_be, mem_wdata);
            end
        end
    end

    // Completion monitor
    initial forever begin
        res_t r;
        @(negedge clk);
        if (rst_n && done) begin
            if (res_q.size() == 0) begin
                note_fail("done_unexpected", ld_data);
            end else begin
                r = res_q.pop_front();
                chk("done_ld", ld_data, r.ld);
                chk("done_ld_hi", ld_data_hi, r.ld_hi);
                chk("done_busy", 32'(busy), 32'd1);
                if (r.access) chk("done_latency", 32'(cyc), 32'(last_beat_cyc + 1));
                else          chk("done_latency", 32'(cyc), 32'(r.start_cyc + 1));
`ifdef SLS_ALIGN_CHECK_EN
                chk("done_abort", 32'(abort), 32'(r.abrt));
`endif
                $display("done ld=%h ld_hi=%h access=%0d abort=%0d", ld_data, ld_data_hi, r.access, r.abrt);
            end
        end
    end

    task automatic run_op(input logic [31:0] ir_v, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] dh, input bit junk, output int lat);
        int c0;
        bit got;
        c0 = cyc;
        model_push(ir_v, a, d, dh, c0);
        ir = ir_v; addr = a; st_data = d; st_data_hi = dh; start = 1'b1;
        got = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            ir = $urandom; addr = $urandom; st_data = $urandom; st_data_hi = $urandom;
            if (done) begin
                got = 1;
                break;
            end
            if (junk && $urandom_range(0, 2) == 0) start = 1'b1;
        end
        lat = cyc - c0;
        if (!got) note_fail("done_timeout", ir_v);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op(output logic [31:0] ir_v, output logic [31:0] a);
        int cls, ac;
        cls  = $urandom_range(0, 11);
        ir_v = $urandom;
        case (cls)
            0, 1, 2: ir_v[27:26] = 2'b01;
            3, 4, 5, 6, 7, 8: begin
                ir_v[27:25] = 3'b000; ir_v[7] = 1'b1; ir_v[4] = 1'b1;
                ir_v[6:5]   = 2'($urandom_range(1, 3));
            end
            9: begin
                ir_v[27:25] = 3'b000; ir_v[7] = 1'b1; ir_v[4] = 1'b1; ir_v[6:5] = 2'b00;
            end
            10: ir_v[27] = 1'b1;
            default: begin
                ir_v[27:25] = 3'b000; ir_v[7] = 1'b1; ir_v[4] = 1'b0;
            end
        endcase
        ac = $urandom_range(0, 9);
        if (ac == 0)      a = 32'hFFFF_FFF8 + 32'(4 * $urandom_range(0, 1));
        else if (ac < 5)  a = $urandom & 32'hFFFF_FFF8;
        else              a = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        bit          got, seen;
        logic [31:0] ir_r, a_r;
        rst_n = 1'b0; start = 1'b0; ir = '0; addr = '0; st_data = '0; st_data_hi = '0;
        pre_mem[32'h0000_0100] = 32'h80FF_1234;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_rw", 32'(mem_rw), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ld", ld_data, 32'd0);
        chk("rst_ld_hi", ld_data_hi, 32'd0);
`ifdef SLS_ALIGN_CHECK_EN
        chk("rst_abort", 32'(abort), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        fixed_delay = 0;
        run_op(32'h0010_00D0, 32'h0000_0103, 32'h0, 32'h0, 0, lat);
        chk("ldrsb_latency", 32'(lat), 32'd2);
        chk("ldrsb_value", ld_data, 32'hFFFF_FF80);
        run_op(32'h0000_00B0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, lat);
        chk("strh_latency", 32'(lat), 32'd2);
        run_op(32'h0000_0000, 32'h0000_0040, 32'h0, 32'h0, 0, lat);
        chk("noop_latency", 32'(lat), 32'd1);
        fixed_delay = 3;
        run_op(32'h0000_00D0, 32'h0000_1000, 32'h0, 32'h0, 0, lat);
        chk("ldrd_latency", 32'(lat), 32'd9);
        chk("ldrd_hi_value", ld_data_hi, mem_word(32'h0000_1004));
        fixed_delay = 1;
        run_op(32'h0000_00F0, 32'hFFFF_FFF8, 32'h1111_2222, 32'h3333_4444, 1, lat);
        fixed_delay = 0;
        run_op(32'h0410_0000, 32'h0000_0002, 32'h0, 32'h0, 0, lat);
`ifdef SLS_ALIGN_CHECK_EN
        chk("ldr_misaligned_latency", 32'(lat), 32'd1);
`else
        chk("ldr_misaligned_latency", 32'(lat), 32'd2);
`endif
        fixed_delay = -1;

        for (int n = 0; n < 250; n++) begin
            rand_op(ir_r, a_r);
            run_op(ir_r, a_r, $urandom, $urandom, ($urandom_range(0, 1) == 1), lat);
        end

        // Asynchronous reset during the second doubleword beat
        fixed_delay = 6;
        model_push(32'h0000_00D0, 32'h0000_2000, 32'h0, 32'h0, cyc);
        ir = 32'h0000_00D0; addr = 32'h0000_2000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req && mem_addr == 32'h0000_2004) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rst_reach_acc1", 32'(got), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        beat_q.delete();
        res_q.delete();
        exp_ld = '0;
        exp_ld_hi = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        chk("midrst_ld", ld_data, 32'd0);
        fixed_delay = -1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 30; n++) begin
            rand_op(ir_r, a_r);
            run_op(ir_r, a_r, $urandom, $urandom, 1, lat);
        end

        repeat (4) @(negedge clk);
        chk("beat_queue_empty", 32'(beat_q.size()), 32'd0);
        chk("result_queue_empty", 32'(res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sls_sequencer.md
# sls_sequencer

Sequential single load/store unit sitting between the control unit and the data RAM. It decodes addressing-mode-2/3 transfers (word, byte, halfword, signed byte/halfword, doubleword) from the instruction register and drives a request/complete handshake to memory. It splits doublewords into two word accesses, aligns store data onto byte lanes, and extracts and extends load data. It generalises the combinational RAM-setting decoder into a parametrised, multi-cycle access sequencer.

## Interface
Parameters:
- `ADDR_W`, 32, width of effective and memory address.
- `DW_STRIDE`, 4, byte offset added for the second doubleword beat.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request from control unit; `ir`, `addr`, `st_data`, `st_data_hi` valid this cycle.
- `ir`  in  32  instruction register.
- `addr`  in  ADDR_W  effective address.
- `st_data`, `st_data_hi`  in  32 each  store data (Rd, Rd+1).
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `ld_data`, `ld_data_hi`  out  32 each  extended load result, second doubleword word.
- `mem_req`  out  1  memory function active.
- `mem_rw`  out  1  1 = read, 0 = write.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_be`  out  4  byte enables, bit n = byte lane n (little-endian).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read data, valid when `mem_moc` high.
- `mem_moc`  in  1  memory operation complete.
- `abort`  out  1  alignment fault pulse (present only with `SLS_ALIGN_CHECK_EN`).

## Operation
- Decode on `start`, all fields latched:
  - Mode 2, `ir[27:26]==01`: `ir[22]`=1 selects an unsigned byte, otherwise a word. Direction comes from L = `ir[20]`.
  - Mode 3, `ir[27:25]==000 && ir[7] && ir[4]`, keyed on SH = `ir[6:5]`:
    - L=1: 01 LDRH, 10 LDRSB, 11 LDRSH.
    - L=0: 01 STRH, 10 LDRD (read), 11 STRD (write).
  - Anything else is a no-op: no memory request, `done` one cycle later.
- FSM states: IDLE, ACC0, ACC1, FIN.
  - IDLE to ACC0 on `start` with a valid decode. A no-op goes IDLE to FIN.
  - ACC0: `mem_req`=1 until `mem_moc` is sampled high. Then go to ACC1 for a doubleword, otherwise FIN.
  - ACC1: `mem_addr` = latched addr + `DW_STRIDE`, modulo 2^ADDR_W. Wait for `mem_moc`, then go to FIN.
  - FIN: `done`=1, then IDLE.
- `start` while `busy` is ignored. `mem_req` stays high continuously across ACC0 to ACC1.
- Lanes: a = `addr[1:0]`.
  - Byte: `mem_be`=1<<a; wdata = byte replicated ×4. Load takes `rdata[8a+7:8a]`, zero- or sign-extended.
  - Half: `mem_be`=0011 or 1100 by `addr[1]`; wdata = half replicated ×2. Load takes the lane half, extended.
  - Word/double: `mem_be`=1111, no rotation.
- `mem_addr` carries the full byte address, low bits included.
- `ld_data` and `ld_data_hi` are updated only on the completing `mem_moc` of a read and hold otherwise. Writes leave them unchanged.

## Timing
- Reset: state IDLE. `busy`, `done`, `mem_req`, `mem_rw`, `mem_be`, `abort` = 0. `mem_addr`, `mem_wdata`, `ld_data`, `ld_data_hi` = 0.
- `rst_n` low mid-access drops `mem_req` immediately, asynchronously. No `done` is produced.
- `start` at cycle 0: `mem_req` high from cycle 1.
- If `mem_moc` arrives in cycle k ≥ 1, a single access gives `done` in cycle k+1. A doubleword with `mem_moc` at cycles k and j > k gives `done` at j+1.
- Minimum latency: single access 2 cycles, doubleword 3 cycles, no-op 1 cycle.
- `mem_moc` outside ACC0/ACC1 is ignored. `mem_moc` held high in both ACC0 and ACC1 completes each beat in one cycle.
- `mem_addr`, `mem_rw`, `mem_be`, `mem_wdata` are stable while `mem_req` is high within a beat.

## Configuration
- `SLS_ALIGN_CHECK_EN` defined:
  - A fault is a half access with `addr[0]`=1, a word access with `addr[1:0]`≠0, or a doubleword with `addr[2:0]`≠0.
  - On a fault, IDLE goes to FIN with no `mem_req`. `abort` and `done` pulse together, and `ld_data` is unchanged.
- Not defined: no `abort` port. Misaligned accesses proceed with the lane rules above, and word/double ignore `addr[1:0]`.

## Test plan
- LDRSB, addr=0x103, rdata=0x80FF_1234, `mem_moc` in first req cycle → `mem_be`=1000, `ld_data`=0xFFFF_FF80, `done` at cycle 2.
- STRH, addr=0x202, st_data=0x0000_ABCD → `mem_rw`=0, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD.
- LDRD, addr=0x1000, `mem_moc` delayed 3 cycles per beat → beat addrs 0x1000 then 0x1004, `ld_data`/`ld_data_hi` = both rdatas, `done` 1 cycle after second `mem_moc`.
- STRD at addr=0xFFFF_FFF8 with ADDR_W=32 → second beat address wraps to 0xFFFF_FFFC; `start` pulsed mid-access is ignored.
- `rst_n` low during ACC1 → `mem_req`=0 asynchronously, no `done`, `busy`=0.
- With `SLS_ALIGN_CHECK_EN`: LDR at addr=0x2 → `mem_req` never asserts, `abort`=`done`=1 at cycle 1. Without the macro: word read at 0x0000_0002, `mem_be`=1111.
